// File: rtl/lc3b_types.sv
// Shared LC-3b word/mask types plus the memory arbiter's state and grant encodings.
// The arbiter's optional round-robin tie-break is enabled by defining MEM_ARB_RR_EN.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10,
    RECOVER = 2'b11
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  // True when the D-side should take the port; prefer_d breaks a simultaneous tie.
  function automatic logic d_wins(input logic d_req, input logic i_req, input logic prefer_d);
    return d_req && (!i_req || prefer_d);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between the LC-3b I-side (read-only) and D-side.
// Optional macro MEM_ARB_RR_EN: alternate the winner on simultaneous requests.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic [15:0] i_rdata,
  output logic        i_resp,

  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_wmask,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_resp,

  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp,

  output logic [1:0]  grant
);

  arb_state_t state_q, state_d;
  logic       d_req;
  logic       prefer_d;

  assign d_req = d_read | d_write;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // 1 = the D-side owned the port most recently.
  logic last_grant_q, last_grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && state_d == SERVE_D) begin
      last_grant_d = 1'b1;
    end else if (state_q == IDLE && state_d == SERVE_I) begin
      last_grant_d = 1'b0;
    end
  end

  assign prefer_d = ~last_grant_q;
`else
  // The D-side holds the older instruction, so it always wins a tie.
  assign prefer_d = 1'b1;
`endif

  always_comb begin
    // NOTE: a default assignment before the case keeps every path driven, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_req || i_read) begin
          state_d = d_wins(d_req, i_read, prefer_d) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: if (pmem_resp) state_d = RECOVER;
      SERVE_D: if (pmem_resp) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wmask   = 2'b00;
    pmem_address = 16'h0000;
    pmem_wdata   = 16'h0000;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    grant        = GRANT_NONE;
    unique case (state_q)
      SERVE_I: begin
        pmem_read    = i_read;
        pmem_address = i_address;
        i_resp       = pmem_resp;
        grant        = GRANT_I;
      end
      SERVE_D: begin
        pmem_read    = d_read;
        pmem_write   = d_write & ~d_read;
        pmem_wmask   = d_wmask;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        grant        = GRANT_D;
      end
      default: ;
    endcase
  end

  // Read data is meaningful only alongside the matching resp pulse.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
